// File: rtl/axis_rr_input_arbiter_if.sv
// AXI4-Stream bundle used on both sides of the round-robin input arbiter.
// LANES > 1 packs several independent streams side by side; lane i lives
// at slice i of each vector.
interface axis_rr_input_arbiter_if #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned TUSER_WIDTH = 128,
  parameter int unsigned LANES       = 1
);

  logic [LANES*DATA_WIDTH-1:0]   tdata;
  logic [LANES*DATA_WIDTH/8-1:0] tstrb;
  logic [LANES*TUSER_WIDTH-1:0]  tuser;
  logic [LANES-1:0]              tvalid;
  logic [LANES-1:0]              tready;
  logic [LANES-1:0]              tlast;

  modport master (
    output tdata,
    output tstrb,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_rr_input_arbiter.sv
// Packet-granular round-robin merge of NUM_QUEUES AXI4-Stream inputs into one
// output, followed by a 2-entry registered output stage. Exports a one-cycle
// per-input packet strobe and the byte count of that packet.
// Optional build macro ARB_TUSER_SRC_PORT_EN: stamps tuser[23:16] of the first
// beat of each packet with the one-hot source input.
module axis_rr_input_arbiter #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_QUEUES           = 5,
  parameter int unsigned C_CNT_WIDTH          = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  axis_rr_input_arbiter_if.slave        s_axis,
  axis_rr_input_arbiter_if.master       m_axis,
  output logic [NUM_QUEUES-1:0]         pkt_fwd,
  output logic [C_CNT_WIDTH-1:0]        bytes_fwd
);

  localparam int unsigned DW   = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned UW   = C_M_AXIS_TUSER_WIDTH;
  localparam int unsigned SDW  = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SSW  = SDW / 8;
  localparam int unsigned SUW  = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned IdxW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int unsigned PcW  = $clog2(SW + 1);

  typedef logic [IdxW-1:0] idx_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  state_e                 state_q, state_d;
  idx_t                   grant_q, grant_d;
  idx_t                   last_grant_q, last_grant_d;
  logic                   run_q;
  beat_t                  ent0_q, ent0_d;
  beat_t                  ent1_q, ent1_d;
  logic [1:0]             count_q, count_d;
  logic [C_CNT_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_QUEUES-1:0]  pkt_fwd_q, pkt_fwd_d;
  logic [C_CNT_WIDTH-1:0] bytes_fwd_q, bytes_fwd_d;

  idx_t                   arb_cand;
  idx_t                   arb_idx;
  logic                   arb_found;
  idx_t                   sel;
  logic                   sel_ok;
  logic                   buf_ready;
  logic                   accept;
  logic                   pop;
  logic [NUM_QUEUES-1:0]  tready_vec;
  beat_t                  in_beat;
  logic [PcW-1:0]         beat_pc;
  logic [C_CNT_WIDTH-1:0] acc_sum;

  function automatic logic [PcW-1:0] popcnt(input logic [SW-1:0] v);
    logic [PcW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      n = n + PcW'(v[i]);
    end
    return n;
  endfunction

  // Round-robin search starting one past the last packet's winner.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_grant_q;
    arb_cand  = last_grant_q;
    for (int unsigned k = 1; k <= NUM_QUEUES; k++) begin
      arb_cand = idx_t'((32'(last_grant_q) + k) % NUM_QUEUES);
      if (!arb_found && s_axis.tvalid[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // Input selection, handshake and the beat presented to the output stage.
  always_comb begin
    sel        = (state_q == StInPkt) ? grant_q : arb_idx;
    sel_ok     = (state_q == StInPkt) || arb_found;
    // run_q keeps all inputs stalled until the cycle after reset release.
    buf_ready  = run_q && (count_q != 2'd2);
    tready_vec = '0;
    if (sel_ok && buf_ready) begin
      tready_vec[sel] = 1'b1;
    end
    accept       = sel_ok && buf_ready && s_axis.tvalid[sel];
    in_beat.data = DW'(s_axis.tdata[32'(sel)*SDW +: SDW]);
    in_beat.strb = SW'(s_axis.tstrb[32'(sel)*SSW +: SSW]);
    in_beat.user = UW'(s_axis.tuser[32'(sel)*SUW +: SUW]);
    in_beat.last = s_axis.tlast[sel];
`ifdef ARB_TUSER_SRC_PORT_EN
    // In StIdle the accepted beat is always the first of a packet.
    if (state_q == StIdle) begin
      in_beat.user[23:16] = 8'(1 << sel);
    end
`else
`endif
    beat_pc = popcnt(in_beat.strb);
    acc_sum = acc_q + C_CNT_WIDTH'(beat_pc);
  end

  assign s_axis.tready = tready_vec;

  // Packet FSM, grant lock, byte accounting and forward strobe.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    pkt_fwd_d    = '0;
    bytes_fwd_d  = bytes_fwd_q;
    if (accept) begin
      if (in_beat.last) begin
        state_d        = StIdle;
        last_grant_d   = sel;
        acc_d          = '0;
        pkt_fwd_d[sel] = 1'b1;
        bytes_fwd_d    = acc_sum;
      end else begin
        state_d = StInPkt;
        grant_d = sel;
        acc_d   = acc_sum;
      end
    end
  end

  // Two-entry output FIFO; ent0 is always the head.
  always_comb begin
    pop     = (count_q != 2'd0) && m_axis.tready[0];
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    case ({accept, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          ent0_d = in_beat;
        end else begin
          ent1_d = in_beat;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Push is only possible at count 0 or 1, and pop needs count >= 1.
        ent0_d = in_beat;
      end
      default: ;
    endcase
  end

  // State registers.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= idx_t'(NUM_QUEUES - 1);
      run_q        <= 1'b0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      count_q      <= 2'd0;
      acc_q        <= '0;
      pkt_fwd_q    <= '0;
      bytes_fwd_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      run_q        <= 1'b1;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      pkt_fwd_q    <= pkt_fwd_d;
      bytes_fwd_q  <= bytes_fwd_d;
    end
  end

  assign m_axis.tvalid = (count_q != 2'd0);
  assign m_axis.tdata  = ent0_q.data;
  assign m_axis.tstrb  = ent0_q.strb;
  assign m_axis.tuser  = ent0_q.user;
  assign m_axis.tlast  = ent0_q.last;
  assign pkt_fwd       = pkt_fwd_q;
  assign bytes_fwd     = bytes_fwd_q;

endmodule

// File: tb/tb_axis_rr_input_arbiter.sv
// Scoreboard bench for axis_rr_input_arbiter: per-input source queues feed the
// slave lanes, expected output beats and forward strobes are queued in the
// order the round-robin rules dictate and compared as the DUT produces them.
module tb_axis_rr_input_arbiter;

  localparam int NQ = 5;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [NQ-1:0] mask;
    logic [CW-1:0] bytes;
  } fwd_t;

  logic          axi_aclk = 1'b0;
  logic          axi_resetn = 1'b0;
  logic [NQ-1:0] pkt_fwd;
  logic [CW-1:0] bytes_fwd;

  axis_rr_input_arbiter_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .LANES(NQ)) s_if ();
  axis_rr_input_arbiter_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .LANES(1))  m_if ();

  axis_rr_input_arbiter #(
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .NUM_QUEUES           (NQ),
    .C_CNT_WIDTH          (CW)
  ) dut (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .pkt_fwd    (pkt_fwd),
    .bytes_fwd  (bytes_fwd)
  );

  always #5 axi_aclk = ~axi_aclk;

  int     n_tests = 0;
  int     n_fail = 0;
  longint cyc = 0;
  beat_t  src_q[NQ][$];
  beat_t  exp_q[$];
  fwd_t   fwd_q[$];
  longint out_cyc[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t make_beat(input int src, input int id, input int k, input int n,
                                      input logic [SW-1:0] last_strb);
    beat_t       b;
    logic [31:0] w;
    w      = {8'(src), 8'(id), 8'(k), 8'hC3};
    b.data = {8{w}};
    b.strb = (k == n - 1) ? last_strb : '1;
    b.user = {4{~w}};
    b.last = (k == n - 1);
    return b;
  endfunction

  task automatic load_pkt(input int src, input int id, input int n, input logic [SW-1:0] ls);
    for (int k = 0; k < n; k++) src_q[src].push_back(make_beat(src, id, k, n, ls));
  endtask

  task automatic expect_pkt(input int src, input int id, input int n, input logic [SW-1:0] ls);
    beat_t b;
    fwd_t  f;
    for (int k = 0; k < n; k++) begin
      b = make_beat(src, id, k, n, ls);
`ifdef ARB_TUSER_SRC_PORT_EN
      if (k == 0) b.user[23:16] = 8'(1 << src);
`endif
      exp_q.push_back(b);
    end
    f.mask  = NQ'(1 << src);
    f.bytes = CW'((n - 1) * SW + $countones(ls));
    fwd_q.push_back(f);
  endtask

  task automatic wait_drain(input int budget);
    int pend;
    for (int t = 0; t < budget; t++) begin
      pend = exp_q.size() + fwd_q.size();
      for (int i = 0; i < NQ; i++) pend += src_q[i].size();
      if (pend == 0) break;
      @(negedge axi_aclk);
    end
    pend = exp_q.size() + fwd_q.size();
    for (int i = 0; i < NQ; i++) pend += src_q[i].size();
    check_eq("drain_pending", 256'(pend), 256'(0));
  endtask

  // Handshake sampling on the active edge (pre-update values): retire source
  // beats, score output beats and forward strobes.
  always @(posedge axi_aclk) begin
    beat_t e;
    fwd_t  f;
    cyc++;
    for (int i = 0; i < NQ; i++) begin
      if (s_if.tvalid[i] && s_if.tready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 256'(1), 256'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("beat_data", 256'(m_if.tdata), 256'(e.data));
        check_eq("beat_strb", 256'(m_if.tstrb), 256'(e.strb));
        check_eq("beat_user", 256'(m_if.tuser), 256'(e.user));
        check_eq("beat_last", 256'(m_if.tlast), 256'(e.last));
      end
    end
    if (pkt_fwd != '0) begin
      if (fwd_q.size() == 0) begin
        check_eq("unexpected_pkt_fwd", 256'(pkt_fwd), 256'(0));
      end else begin
        f = fwd_q.pop_front();
        check_eq("pkt_fwd", 256'(pkt_fwd), 256'(f.mask));
        check_eq("bytes_fwd", 256'(bytes_fwd), 256'(f.bytes));
      end
    end
  end

  // Source drivers: present the head of each source queue.
  always @(negedge axi_aclk) begin
    beat_t b;
    for (int i = 0; i < NQ; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_if.tvalid[i]           = 1'b1;
        s_if.tdata[i*DW +: DW]   = b.data;
        s_if.tstrb[i*SW +: SW]   = b.strb;
        s_if.tuser[i*UW +: UW]   = b.user;
        s_if.tlast[i]            = b.last;
      end else begin
        s_if.tvalid[i]           = 1'b0;
        s_if.tdata[i*DW +: DW]   = '0;
        s_if.tstrb[i*SW +: SW]   = '0;
        s_if.tuser[i*UW +: UW]   = '0;
        s_if.tlast[i]            = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_if.tready = 1'b1;
    repeat (3) @(negedge axi_aclk);
    axi_resetn = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      @(negedge axi_aclk);
      check_eq("idle_m_tvalid", 256'(m_if.tvalid), 256'(0));
      check_eq("idle_s_tready", 256'(s_if.tready), 256'(0));
      check_eq("idle_pkt_fwd", 256'(pkt_fwd), 256'(0));
      check_eq("idle_bytes_fwd", 256'(bytes_fwd), 256'(0));
    end

    // Three 3-beat packets on 0,2,4: served in order, back to back.
    out_cyc.delete();
    load_pkt(0, 1, 3, '1);
    load_pkt(2, 2, 3, '1);
    load_pkt(4, 3, 3, '1);
    expect_pkt(0, 1, 3, '1);
    expect_pkt(2, 2, 3, '1);
    expect_pkt(4, 3, 3, '1);
    wait_drain(100);
    check_eq("rr3_beats", 256'(out_cyc.size()), 256'(9));
    if (out_cyc.size() == 9) check_eq("rr3_no_bubble", 256'(out_cyc[8] - out_cyc[0]), 256'(8));
    @(negedge axi_aclk);
    check_eq("bytes_fwd_hold", 256'(bytes_fwd), 256'(96));

    // Fairness: 1-beat packets on inputs 1 and 3 alternate.
    for (int p = 0; p < 3; p++) begin
      load_pkt(1, 10 + p, 1, '1);
      load_pkt(3, 20 + p, 1, '1);
    end
    for (int p = 0; p < 3; p++) begin
      expect_pkt(1, 10 + p, 1, '1);
      expect_pkt(3, 20 + p, 1, '1);
    end
    wait_drain(100);

    // Backpressure mid-packet.
    load_pkt(0, 30, 6, '1);
    expect_pkt(0, 30, 6, '1);
    repeat (2) @(negedge axi_aclk);
    m_if.tready = 1'b0;
    repeat (5) @(negedge axi_aclk);
    check_eq("stall_s_tready", 256'(s_if.tready), 256'(0));
    check_eq("stall_m_tvalid", 256'(m_if.tvalid), 256'(1));
    m_if.tready = 1'b1;
    wait_drain(100);

    // Partial last-beat strobe.
    load_pkt(2, 40, 2, 32'h0000_000F);
    expect_pkt(2, 40, 2, 32'h0000_000F);
    wait_drain(100);
    @(negedge axi_aclk);
    check_eq("partial_bytes_hold", 256'(bytes_fwd), 256'(36));

    // Reset in the middle of a packet.
    load_pkt(0, 50, 4, '1);
    expect_pkt(0, 50, 4, '1);
    repeat (2) @(negedge axi_aclk);
    axi_resetn = 1'b0;
    #1;
    check_eq("rst_m_tvalid", 256'(m_if.tvalid), 256'(0));
    check_eq("rst_s_tready", 256'(s_if.tready), 256'(0));
    check_eq("rst_pkt_fwd", 256'(pkt_fwd), 256'(0));
    for (int i = 0; i < NQ; i++) src_q[i].delete();
    exp_q.delete();
    fwd_q.delete();
    repeat (3) @(negedge axi_aclk);
    axi_resetn = 1'b1;
    load_pkt(4, 60, 1, '1);
    load_pkt(0, 61, 1, '1);
    expect_pkt(0, 61, 1, '1);
    expect_pkt(4, 60, 1, '1);
    wait_drain(100);

    repeat (3) @(negedge axi_aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rr_input_arbiter.md
Name: axis_rr_input_arbiter

Overview:
Merges NUM_QUEUES slave AXI4-Stream inputs (per-port RX paths) into one master AXI4-Stream toward the datapath/output-queue stage. Arbitration is packet-granular round-robin, so a packet is never interleaved. A 2-entry registered output stage gives full throughput and timing isolation. Per-packet forward strobes and byte counts are exported for the wrapper's AXI-Lite statistics registers.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, master tdata width (bits)
C_S_AXIS_DATA_WIDTH, 256, slave tdata width per input; must equal C_M_AXIS_DATA_WIDTH
C_M_AXIS_TUSER_WIDTH, 128, master tuser width
C_S_AXIS_TUSER_WIDTH, 128, slave tuser width per input; must equal C_M_AXIS_TUSER_WIDTH
NUM_QUEUES, 5, number of slave inputs (2..8)
C_CNT_WIDTH, 32, width of bytes_fwd

Ports:
axi_aclk  in  1  clock, all logic rising-edge
axi_resetn  in  1  reset, asynchronous, active-low
s_axis_tdata  in  NUM_QUEUES*C_S_AXIS_DATA_WIDTH  input i at slice i
s_axis_tstrb  in  NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8  byte strobes, slice i
s_axis_tuser  in  NUM_QUEUES*C_S_AXIS_TUSER_WIDTH  metadata, slice i
s_axis_tvalid  in  NUM_QUEUES  per-input valid
s_axis_tready  out  NUM_QUEUES  per-input ready
s_axis_tlast  in  NUM_QUEUES  per-input last
m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  merged data
m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  merged strobes
m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  merged metadata
m_axis_tvalid  out  1  merged valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  merged last
pkt_fwd  out  NUM_QUEUES  one-cycle pulse, packet from input i fully accepted
bytes_fwd  out  C_CNT_WIDTH  byte count of that packet, valid while any pkt_fwd bit high

Behaviour:
- Reset (async assert, sync-released use): m_axis_tvalid=0, s_axis_tready=0, pkt_fwd=0, bytes_fwd=0, skid buffer empty, state=IDLE, last_grant=NUM_QUEUES-1 (input 0 has first priority). Other m_axis_* = 0.
- Reset mid-packet: partial packet discarded from buffer; downstream sees truncation; no recovery logic required.
- Beat accepted on input i when s_axis_tvalid[i] && s_axis_tready[i]. At most one s_axis_tready bit high per cycle; only the granted input.
- s_axis_tready[grant] = buffer not full (registered count <2); all other bits 0.
- FSM IDLE: grant = first i with tvalid set, searching (last_grant+1) mod N upward with wrap. None valid -> no tready. First beat accepted: if tlast -> stay IDLE, last_grant<=grant; else -> IN_PKT with grant locked.
- FSM IN_PKT: grant locked; other inputs ignored regardless of tvalid. Accepted tlast beat -> IDLE, last_grant<=grant. Next packet may be accepted in the following cycle (no bubble between packets).
- Output stage: 2-entry FIFO of {tdata,tstrb,tuser,tlast}; m_axis_* driven from head register. Latency input-accept to m_axis_tvalid = 1 cycle. Simultaneous push and pop at count 2 not allowed (tready already 0); at count 1 count unchanged. Sustains 1 beat/cycle with m_axis_tready held high.
- Byte accounting: per-beat popcount of tstrb, accumulated in C_CNT_WIDTH register (wraps modulo 2^C_CNT_WIDTH), cleared on tlast. Cycle after tlast acceptance: pkt_fwd[grant]=1 one cycle, bytes_fwd = total including tlast beat; bytes_fwd holds until next pulse.
- tvalid deassert mid-packet on granted input: arbiter waits in IN_PKT, no re-arbitration.

Optional Feature:
ARB_TUSER_SRC_PORT_EN: when defined, m_axis_tuser[23:16] of the first beat of each packet is overwritten with one-hot (1<<grant) (8 bits, upper bits zero for NUM_QUEUES<8); later beats and other tuser bits pass unmodified. When undefined, tuser passes through unmodified on every beat.

Test Plan:
- Reset release, all inputs idle -> m_axis_tvalid=0, s_axis_tready=0, pkt_fwd=0, bytes_fwd=0 for 10 cycles.
- Inputs 0,2,4 each hold one 3-beat packet (full strobes, 32 B/beat), m_axis_tready=1 -> output order 0,2,4, no interleave, no bubbles, pkt_fwd pulses 0x01,0x04,0x10 each with bytes_fwd=96.
- Input 1 streams back-to-back 1-beat packets while input 3 valid -> grants alternate 1,3,1,3 (round-robin fairness).
- Mid-packet m_axis_tready low 5 cycles -> buffer fills to 2, s_axis_tready=0, no beat lost/duplicated, order preserved.
- Last beat tstrb=0x0000000F on 2-beat packet from input 2 -> bytes_fwd=36, pkt_fwd=0x04; with ARB_TUSER_SRC_PORT_EN first-beat tuser[23:16]=0x04.
- Assert axi_resetn low mid-packet -> same cycle m_axis_tvalid=0, s_axis_tready=0; after release input 0 wins first.
